// File: rtl/pipe_instr_dec.sv
// rtl/pipe_instr_dec.sv - RV32I decode stage with register file, bypass, load-use stall and hold refresh
module pipe_instr_dec #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int FWD_EN = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_is_load,
    input  logic [AW-1:0]   ex_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [11:0]     out_ctrl,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_alu_in2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_branch_target,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2,
    output logic [AW-1:0]   out_rd,
    output logic [15:0]     hazard_cnt
);

    // Opcodes understood by the control decoder; anything else decodes to an all-zero control word.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Immediate select encoding carried in ctrl[10:9].
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    logic [XLEN-1:0] r_regs [NREG];

    logic            r_out_valid;
    logic [11:0]     r_ctrl;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_alu_in2;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_branch_target;
    logic [AW-1:0]   r_rs1;
    logic [AW-1:0]   r_rs2;
    logic [AW-1:0]   r_rd;
    logic [15:0]     r_hazard_cnt;

    logic [6:0]      w_opcode;
    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic [AW-1:0]   w_rd;
    logic [11:0]     w_ctrl;
    logic            w_zero;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic [XLEN-1:0] w_alu_in2;
    logic            w_hazard;
    logic            w_accept;
    logic            w_hold;
    logic            w_refresh1;
    logic            w_refresh2;

    assign w_opcode = in_instr[6:0];
    assign w_rs1    = AW'(in_instr[19:15]);
    assign w_rs2    = AW'(in_instr[24:20]);
    assign w_rd     = AW'(in_instr[11:7]);
    // The branch-compare result is not known in decode, so the decoder's zero input is tied low.
    assign w_zero   = 1'b0;

    // Control word: {regwrite, immsel[1:0], alusrc, memread, memwrite, memtoreg, branch, pcsrc, aluop[2:0]}.
    always_comb begin
        w_ctrl = '0;
        case (w_opcode)
            OP_R:      w_ctrl = {1'b1, IMM_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010};
            OP_IMM:    w_ctrl = {1'b1, IMM_I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011};
            OP_LOAD:   w_ctrl = {1'b1, IMM_I, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000};
            OP_STORE:  w_ctrl = {1'b0, IMM_S, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
            OP_BRANCH: w_ctrl = {1'b0, IMM_B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001};
            OP_JAL:    w_ctrl = {1'b1, IMM_J, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
            OP_JALR:   w_ctrl = {1'b1, IMM_I, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
            default:   w_ctrl = '0;
        endcase
        // pcsrc = jump | (branch & zero)
        w_ctrl[3] = w_ctrl[3] | (w_ctrl[4] & w_zero);
    end

    // Immediate extraction chosen by the decoder's immediate select.
    always_comb begin
        w_imm32 = '0;
        case (w_ctrl[10:9])
            IMM_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            IMM_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            IMM_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                              in_instr[11:8], 1'b0};
            IMM_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                              in_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));

    // Register reads, with the write-back port bypassed into the read when enabled.
    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (w_rs1 != '0) begin
            if ((FWD_EN != 0) && wb_we && (wb_addr == w_rs1)) w_rs1_data = wb_data;
            else                                            w_rs1_data = r_regs[w_rs1];
        end
        if (w_rs2 != '0) begin
            if ((FWD_EN != 0) && wb_we && (wb_addr == w_rs2)) w_rs2_data = wb_data;
            else                                            w_rs2_data = r_regs[w_rs2];
        end
    end

    assign w_alu_in2 = w_ctrl[8] ? w_imm : w_rs2_data;

    assign w_hazard = in_valid & ex_is_load & (ex_rd != '0) & ((ex_rd == w_rs1) | (ex_rd == w_rs2));
    assign in_ready = ~reset & (~r_out_valid | out_ready) & ~w_hazard & ~flush;
    assign w_accept = in_valid & in_ready;

    // A stalled bundle picks up write-backs to its source registers so it never goes stale.
    assign w_hold     = r_out_valid & ~out_ready;
    assign w_refresh1 = w_hold & wb_we & (wb_addr != '0) & (wb_addr == r_rs1);
    assign w_refresh2 = w_hold & wb_we & (wb_addr != '0) & (wb_addr == r_rs2);

    // Register file: cleared by reset, index 0 never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (wb_we && (wb_addr != '0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Output bundle: load on accept, drop on consume or flush, refresh sources while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid     <= 1'b0;
            r_ctrl          <= '0;
            r_rs1_data      <= '0;
            r_rs2_data      <= '0;
            r_alu_in2       <= '0;
            r_imm           <= '0;
            r_pc            <= '0;
            r_branch_target <= '0;
            r_rs1           <= '0;
            r_rs2           <= '0;
            r_rd            <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid     <= 1'b1;
            r_ctrl          <= w_ctrl;
            r_rs1_data      <= w_rs1_data;
            r_rs2_data      <= w_rs2_data;
            r_alu_in2       <= w_alu_in2;
            r_imm           <= w_imm;
            r_pc            <= in_pc;
            r_branch_target <= in_pc + w_imm;
            r_rs1           <= w_rs1;
            r_rs2           <= w_rs2;
            r_rd            <= w_rd;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            if (w_refresh1) r_rs1_data <= wb_data;
            if (w_refresh2) begin
                r_rs2_data <= wb_data;
                if (!r_ctrl[8]) r_alu_in2 <= wb_data;
            end
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk) begin
        if (reset)                                  r_hazard_cnt <= '0;
        else if (w_hazard && (r_hazard_cnt != 16'hFFFF)) r_hazard_cnt <= r_hazard_cnt + 16'd1;
    end

    assign out_valid         = r_out_valid;
    assign out_ctrl          = r_ctrl;
    assign out_rs1_data      = r_rs1_data;
    assign out_rs2_data      = r_rs2_data;
    assign out_alu_in2       = r_alu_in2;
    assign out_imm           = r_imm;
    assign out_pc            = r_pc;
    assign out_branch_target = r_branch_target;
    assign out_rs1           = r_rs1;
    assign out_rs2           = r_rs2;
    assign out_rd            = r_rd;
    assign hazard_cnt        = r_hazard_cnt;

endmodule

// File: tb/tb_pipe_instr_dec.sv
// tb/tb_pipe_instr_dec.sv - directed and randomized checks of pipe_instr_dec against a reference model
module tb_pipe_instr_dec;

    typedef struct packed {
        logic        valid;
        logic [11:0] ctrl;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] alu_in2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] bt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } bundle_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, wb_we, ex_is_load, flush, out_ready;
    logic [31:0] in_instr, in_pc, wb_data;
    logic [4:0]  wb_addr, ex_rd;

    // index 0: FWD_EN=1, index 1: FWD_EN=0
    logic        rdy  [2];
    logic        ov   [2];
    logic [11:0] octl [2];
    logic [31:0] ors1d[2], ors2d[2], oalu[2], oimm[2], opc[2], obt[2];
    logic [4:0]  ors1 [2], ors2[2], ord[2];
    logic [15:0] ocnt [2];

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_regs [32];
    bundle_t     m_out  [2];
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    pipe_instr_dec #(.XLEN(32), .NREG(32), .FWD_EN(1)) dut_fwd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .in_instr(in_instr),
        .in_pc(in_pc), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush), .out_valid(ov[0]),
        .out_ready(out_ready), .out_ctrl(octl[0]), .out_rs1_data(ors1d[0]),
        .out_rs2_data(ors2d[0]), .out_alu_in2(oalu[0]), .out_imm(oimm[0]), .out_pc(opc[0]),
        .out_branch_target(obt[0]), .out_rs1(ors1[0]), .out_rs2(ors2[0]), .out_rd(ord[0]),
        .hazard_cnt(ocnt[0])
    );

    pipe_instr_dec #(.XLEN(32), .NREG(32), .FWD_EN(0)) dut_nofwd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .in_instr(in_instr),
        .in_pc(in_pc), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush), .out_valid(ov[1]),
        .out_ready(out_ready), .out_ctrl(octl[1]), .out_rs1_data(ors1d[1]),
        .out_rs2_data(ors2d[1]), .out_alu_in2(oalu[1]), .out_imm(oimm[1]), .out_pc(opc[1]),
        .out_branch_target(obt[1]), .out_rs1(ors1[1]), .out_rs2(ors2[1]), .out_rd(ord[1]),
        .hazard_cnt(ocnt[1])
    );

    function automatic bundle_t observed(input int k);
        bundle_t b;
        b = '{ov[k], octl[k], ors1d[k], ors2d[k], oalu[k], oimm[k], opc[k], obt[k],
              ors1[k], ors2[k], ord[k]};
        return b;
    endfunction

    // Control word per instruction class, written straight from the field table.
    function automatic logic [11:0] ref_ctrl(input logic [6:0] op);
        case (op)
            7'h33:   return 12'h802;
            7'h13:   return 12'h903;
            7'h03:   return 12'h9A0;
            7'h23:   return 12'h340;
            7'h63:   return 12'h411;
            7'h6F:   return 12'hE08;
            7'h67:   return 12'h908;
            default: return 12'h000;
        endcase
    endfunction

    // Immediate value by arithmetic on the signed instruction word.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [1:0] sel);
        logic signed [31:0] s;
        s = ins;
        case (sel)
            2'd0:    return 32'(s >>> 20);
            2'd1:    return 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
            2'd2:    return 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11) |
                            (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            default: return 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12) |
                            (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] r, input int k);
        if (r == 0) return 32'h0;
        if (k == 0 && wb_we && wb_addr == r) return wb_data;
        return m_regs[r];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        reset = 0; in_valid = 0; in_instr = 0; in_pc = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        ex_is_load = 0; ex_rd = 0; flush = 0; out_ready = 1;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1; in_valid = 1; in_instr = 32'h00828313; wb_we = 1; wb_addr = 5;
        wb_data = 32'hDEAD; flush = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (rdy[k] !== 1'b0) $display("FAIL reset_in_ready[%0d]: got %b want 0", k, rdy[k]);
            else n_pass++;
        end
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (observed(k) !== '0) $display("FAIL reset_outputs[%0d]: got %h want 0", k, observed(k));
            else n_pass++;
            n_total++;
            if (ocnt[k] !== 16'h0) $display("FAIL reset_cnt[%0d]: got %h want 0", k, ocnt[k]);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_basic;
        wb_we = 1; wb_addr = 5; wb_data = 32'h1234;
        tick();
        wb_we = 0;
        in_valid = 1; in_instr = 32'h00828313; in_pc = 32'h100;
        #1;
        n_total++;
        if (rdy[0] !== 1'b1) $display("FAIL basic_in_ready: got %b want 1", rdy[0]); else n_pass++;
        tick();
        in_valid = 0;
        n_total++;
        if (ov[0] !== 1'b1) $display("FAIL basic_valid: got %b want 1", ov[0]); else n_pass++;
        n_total++;
        if (ors1d[0] !== 32'h1234) $display("FAIL basic_rs1_data: got %h want 1234", ors1d[0]); else n_pass++;
        n_total++;
        if (oimm[0] !== 32'h8 || oalu[0] !== 32'h8)
            $display("FAIL basic_imm_alu: got imm=%h alu=%h want 8/8", oimm[0], oalu[0]);
        else n_pass++;
        n_total++;
        if (ord[0] !== 5'd6 || ors1[0] !== 5'd5 || octl[0] !== 12'h903 || obt[0] !== 32'h108)
            $display("FAIL basic_fields: got rd=%0d rs1=%0d ctrl=%h bt=%h want 6/5/903/108",
                     ord[0], ors1[0], octl[0], obt[0]);
        else n_pass++;
    endtask

    task automatic test_bypass;
        in_valid = 1; in_instr = 32'h005283B3; in_pc = 32'h104;
        wb_we = 1; wb_addr = 5; wb_data = 32'hAAAA;
        tick();
        in_valid = 0; wb_we = 0;
        n_total++;
        if (ors1d[0] !== 32'hAAAA || ors2d[0] !== 32'hAAAA || oalu[0] !== 32'hAAAA || octl[0] !== 12'h802)
            $display("FAIL bypass_fwd: got %h %h %h ctrl=%h want aaaa x3 ctrl=802",
                     ors1d[0], ors2d[0], oalu[0], octl[0]);
        else n_pass++;
        n_total++;
        if (ors1d[1] !== 32'h1234 || ors2d[1] !== 32'h1234)
            $display("FAIL bypass_nofwd: got %h %h want 1234 1234", ors1d[1], ors2d[1]);
        else n_pass++;
    endtask

    task automatic test_hazard;
        in_valid = 1; in_instr = 32'h00828313; in_pc = 32'h200;
        ex_is_load = 1; ex_rd = 5;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++;
            if (rdy[0] !== 1'b0) $display("FAIL hazard_in_ready_c%0d: got %b want 0", c, rdy[0]); else n_pass++;
            tick();
            n_total++;
            if (ov[0] !== 1'b0) $display("FAIL hazard_bubble_c%0d: got %b want 0", c, ov[0]); else n_pass++;
        end
        ex_is_load = 0;
        tick();
        in_valid = 0;
        n_total++;
        if (ocnt[0] !== 16'd3) $display("FAIL hazard_cnt: got %0d want 3", ocnt[0]); else n_pass++;
        n_total++;
        if (ov[0] !== 1'b1 || ors1d[0] !== 32'hAAAA)
            $display("FAIL hazard_release: got v=%b rs1=%h want 1/aaaa", ov[0], ors1d[0]);
        else n_pass++;
    endtask

    task automatic test_hold;
        in_valid = 1; in_instr = 32'h00828313; in_pc = 32'h300; out_ready = 1;
        tick();
        in_valid = 0; out_ready = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_total++;
            if (rdy[0] !== 1'b0) $display("FAIL hold_in_ready_c%0d: got %b want 0", c, rdy[0]); else n_pass++;
            tick();
            n_total++;
            if (ov[0] !== 1'b1 || ors1d[0] !== 32'hAAAA)
                $display("FAIL hold_c%0d: got v=%b rs1=%h want 1/aaaa", c, ov[0], ors1d[0]);
            else n_pass++;
        end
        wb_we = 1; wb_addr = 5; wb_data = 32'h55;
        tick();
        wb_we = 0;
        n_total++;
        if (ov[0] !== 1'b1 || ors1d[0] !== 32'h55 || oalu[0] !== 32'h8)
            $display("FAIL hold_refresh: got v=%b rs1=%h alu=%h want 1/55/8", ov[0], ors1d[0], oalu[0]);
        else n_pass++;
        out_ready = 1;
        tick();
        n_total++;
        if (ov[0] !== 1'b0) $display("FAIL hold_consume_once: got %b want 0", ov[0]); else n_pass++;
    endtask

    task automatic test_branch_flush;
        in_valid = 1; in_instr = 32'h02208063; in_pc = 32'hFFFFFFF0;
        tick();
        n_total++;
        if (ov[0] !== 1'b1 || obt[0] !== 32'h10 || oimm[0] !== 32'h20 || octl[0] !== 12'h411)
            $display("FAIL branch_target: got v=%b bt=%h imm=%h ctrl=%h want 1/10/20/411",
                     ov[0], obt[0], oimm[0], octl[0]);
        else n_pass++;
        in_instr = 32'h00828313; flush = 1;
        #1;
        n_total++;
        if (rdy[0] !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", rdy[0]); else n_pass++;
        tick();
        flush = 0; in_valid = 0;
        n_total++;
        if (ov[0] !== 1'b0) $display("FAIL flush_valid: got %b want 0", ov[0]); else n_pass++;
    endtask

    task automatic test_reset_hold;
        in_valid = 1; in_instr = 32'h00828313; in_pc = 32'h400;
        tick();
        in_valid = 0; out_ready = 0;
        tick();
        reset = 1; in_valid = 1; wb_we = 1; wb_addr = 5; wb_data = 32'h77;
        tick();
        reset = 0; wb_we = 0; out_ready = 1;
        n_total++;
        if (observed(0) !== '0 || ocnt[0] !== 16'h0)
            $display("FAIL reset_hold_outputs: got %h cnt=%h want 0", observed(0), ocnt[0]);
        else n_pass++;
        in_instr = 32'h00028313;
        tick();
        in_valid = 0;
        n_total++;
        if (ov[0] !== 1'b1 || ors1d[0] !== 32'h0)
            $display("FAIL reset_hold_x5: got v=%b rs1=%h want 1/0", ov[0], ors1d[0]);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [6:0] ops [8];
        bundle_t    nb;
        logic       haz, acc;
        logic [4:0] r1, r2;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
        for (int c = 0; c < 600; c++) begin
            reset      = (c == 0) || ($urandom_range(0, 63) == 0);
            in_valid   = $urandom_range(0, 3) != 0;
            in_instr   = $urandom;
            in_instr[6:0]   = ops[$urandom_range(0, 7)];
            in_instr[11:7]  = 5'($urandom_range(0, 7));
            in_instr[19:15] = 5'($urandom_range(0, 7));
            in_instr[24:20] = 5'($urandom_range(0, 7));
            in_pc      = $urandom;
            wb_we      = $urandom_range(0, 1) == 1;
            wb_addr    = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            ex_is_load = $urandom_range(0, 3) == 0;
            ex_rd      = 5'($urandom_range(0, 7));
            flush      = $urandom_range(0, 15) == 0;
            out_ready  = $urandom_range(0, 2) != 0;

            r1  = in_instr[19:15];
            r2  = in_instr[24:20];
            haz = in_valid && ex_is_load && ex_rd != 0 && (ex_rd == r1 || ex_rd == r2);
            #1;
            for (int k = 0; k < 2; k++) begin
                acc = !reset && (!m_out[k].valid || out_ready) && !haz && !flush;
                n_total++;
                if (rdy[k] !== acc)
                    $display("FAIL rand_in_ready[%0d] c%0d: got %b want %b", k, c, rdy[k], acc);
                else n_pass++;
                acc = acc && in_valid;
                nb.valid    = 1'b1;
                nb.ctrl     = ref_ctrl(in_instr[6:0]);
                nb.rs1_data = ref_read(r1, k);
                nb.rs2_data = ref_read(r2, k);
                nb.imm      = ref_imm(in_instr, nb.ctrl[10:9]);
                nb.alu_in2  = nb.ctrl[8] ? nb.imm : nb.rs2_data;
                nb.pc       = in_pc;
                nb.bt       = in_pc + nb.imm;
                nb.rs1      = r1;
                nb.rs2      = r2;
                nb.rd       = in_instr[11:7];
                if (reset)               m_out[k] = '0;
                else if (flush)          m_out[k].valid = 1'b0;
                else if (acc)            m_out[k] = nb;
                else if (out_ready)      m_out[k].valid = 1'b0;
                else if (m_out[k].valid && wb_we && wb_addr != 0) begin
                    if (wb_addr == m_out[k].rs1) m_out[k].rs1_data = wb_data;
                    if (wb_addr == m_out[k].rs2) begin
                        m_out[k].rs2_data = wb_data;
                        if (!m_out[k].ctrl[8]) m_out[k].alu_in2 = wb_data;
                    end
                end
            end
            if (reset)                      for (int r = 0; r < 32; r++) m_regs[r] = 0;
            else if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
            if (reset)                           m_cnt = 0;
            else if (haz && m_cnt != 16'hFFFF)   m_cnt = m_cnt + 1;
            tick();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (ov[k] !== m_out[k].valid || ocnt[k] !== m_cnt)
                    $display("FAIL rand_valid_cnt[%0d] c%0d: got %b/%0d want %b/%0d",
                             k, c, ov[k], ocnt[k], m_out[k].valid, m_cnt);
                else n_pass++;
                if (m_out[k].valid) begin
                    n_total++;
                    if (observed(k) !== m_out[k])
                        $display("FAIL rand_bundle[%0d] c%0d: got %h want %h", k, c, observed(k), m_out[k]);
                    else n_pass++;
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        tick();
        test_reset();
        test_basic();
        test_bypass();
        test_hazard();
        test_hold();
        test_branch_flush();
        test_reset_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
